// File: rtl/eth_tx_frame_reader.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_reader
//
// Reads one Ethernet frame out of the shared 2048x8 packet buffer through its
// fabric-side port and streams it byte-by-byte to the MAC transmit path, then
// holds off for an inter-frame gap before signalling done.
//
// Optional feature macro: ETH_TX_PAD_EN
//   When defined, frames with 0 < len < MIN_LEN are extended to MIN_LEN bytes
//   with internally generated 0x00 bytes (no buffer reads for the pad bytes).
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle pulse that begins a frame (ignored while busy)
//   start_addr           buffer offset of the first byte
//   frame_len            byte count (clamped to 2048)
//   busy                 frame in progress, including the inter-frame gap
//   done                 one-cycle pulse at the end of the gap
//   buf_address, buf_rd  buffer read port (address / read enable)
//   buf_readdata         buffer data, valid one cycle after buf_rd
//   tx_data, tx_valid,   byte stream to the MAC
//   tx_ready, tx_sop,
//   tx_eop
//   dbg_state            current FSM state (0 IDLE, 1 FETCH, 2 DRAIN, 3 GAP)
//
// Handshake: a byte moves on a clock edge where tx_valid and tx_ready are both
// high; while tx_valid is high and tx_ready low, tx_data/tx_sop/tx_eop hold.
// ---------------------------------------------------------------------------
module eth_tx_frame_reader #(
  parameter int ADDR_W     = 11,
  parameter int LEN_W      = 12,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_rd,
  input  logic [7:0]        buf_readdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int               GAP_W   = $clog2(IFG_CYCLES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0]  r_len;      // bytes to read from the buffer
  logic [LEN_W-1:0]  r_tot;      // bytes to emit (len, or padded length)
  logic [LEN_W-1:0]  r_rd_cnt;
  logic [LEN_W-1:0]  r_out_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_d1;    // a read issued last cycle lands this cycle

  logic [7:0]        r_fifo [2];
  logic              r_wr_idx;
  logic              r_rd_idx;
  logic [1:0]        r_cnt;

  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_tot;
  logic              w_pad_valid;
  logic              w_valid;
  logic              w_xfer;
  logic              w_fifo_pop;
  logic [1:0]        w_resv;
  logic              w_issue;

  assign w_len = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;

`ifdef ETH_TX_PAD_EN
  localparam logic [LEN_W-1:0] PAD_LEN = LEN_W'(MIN_LEN);
  assign w_tot = ((w_len != '0) && (w_len < PAD_LEN)) ? PAD_LEN : w_len;
  // Pad bytes follow once every real byte has left the FIFO.
  assign w_pad_valid = (r_state == S_DRAIN) && (r_out_cnt >= r_len) &&
                       (r_out_cnt < r_tot);
`else
  assign w_tot       = w_len;
  assign w_pad_valid = 1'b0;
`endif

  assign w_valid    = (r_cnt != 2'd0) || w_pad_valid;
  assign w_xfer     = w_valid && tx_ready;
  assign w_fifo_pop = (r_cnt != 2'd0) && tx_ready;

  // Slots committed after this cycle's pop: stored entries plus the read whose
  // data arrives this cycle. Counting the same-cycle pop lets a freed slot be
  // reused immediately, which is what keeps one byte per cycle flowing with
  // only two entries.
  assign w_resv  = r_cnt + {1'b0, r_rd_d1} - {1'b0, w_fifo_pop};
  assign w_issue = (r_state == S_FETCH) && (r_rd_cnt != r_len) && (w_resv < 2'd2);

  assign buf_rd      = w_issue;
  assign buf_address = r_rd_ptr;
  assign tx_valid    = w_valid;
  assign tx_data     = w_pad_valid ? 8'h00 : r_fifo[r_rd_idx];
  assign tx_sop      = w_valid && (r_out_cnt == '0);
  assign tx_eop      = w_valid && (r_out_cnt == (r_tot - LEN_W'(1)));
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

  // Two-entry skid FIFO fed by the buffer's one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_idx  <= 1'b0;
      r_rd_idx  <= 1'b0;
      r_cnt     <= 2'd0;
      r_rd_d1   <= 1'b0;
    end else begin
      r_rd_d1 <= w_issue;
      if (r_rd_d1) begin
        r_fifo[r_wr_idx] <= buf_readdata;
        r_wr_idx         <= ~r_wr_idx;
      end
      if (w_fifo_pop) r_rd_idx <= ~r_rd_idx;
      r_cnt <= r_cnt + {1'b0, r_rd_d1} - {1'b0, w_fifo_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_rd_ptr  <= '0;
      r_len     <= '0;
      r_tot     <= '0;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_gap_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_xfer) r_out_cnt <= r_out_cnt + LEN_W'(1);

      case (r_state)
        S_IDLE: begin
          // A start landing in the done cycle is dropped.
          if (start && !r_done) begin
            r_rd_ptr  <= start_addr;
            r_len     <= w_len;
            r_tot     <= w_tot;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_busy    <= 1'b1;
            if (w_len == '0) begin
              // Empty frame: the gap runs one cycle longer than after a
              // real frame, so the counter starts one lower.
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_rd_cnt <= r_rd_cnt + LEN_W'(1);
            if ((r_rd_cnt + LEN_W'(1)) == r_len) r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (w_xfer && (r_out_cnt == (r_tot - LEN_W'(1)))) begin
            r_gap_cnt <= GAP_W'(1);
            r_state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_reader.sv
// ---------------------------------------------------------------------------
// Testbench for eth_tx_frame_reader: a behavioural buffer model, directed and
// randomized frames, and a reference expectation built from the buffer
// contents, start offset and length.
// ---------------------------------------------------------------------------
module tb_eth_tx_frame_reader;

  localparam int ADDR_W  = 11;
  localparam int LEN_W   = 12;
  localparam int IFG     = 12;
  localparam int MIN_LEN = 60;
  localparam int DEPTH   = 2048;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] buf_address;
  logic              buf_rd;
  logic [7:0]        buf_readdata = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              tx_sop;
  logic              tx_eop;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  eth_tx_frame_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_addr   (start_addr),
    .frame_len    (frame_len),
    .busy         (busy),
    .done         (done),
    .buf_address  (buf_address),
    .buf_rd       (buf_rd),
    .buf_readdata (buf_readdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_sop       (tx_sop),
    .tx_eop       (tx_eop),
    .dbg_state    (dbg_state)
  );

  // ---------------- buffer model and read monitor ----------------
  logic [7:0] mem [DEPTH];
  int         cyc = 0;
  int         rd_pulses = 0;
  int         addr_q [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (buf_rd) begin
      buf_readdata <= mem[buf_address];
      rd_pulses = rd_pulses + 1;
      addr_q.push_back(int'(buf_address));
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver / monitor for one frame ----------------
  // inj_k >= 0 : pulse a stray start on loop iteration inj_k
  // rst_at >= 0: pulse reset_n low once rst_at bytes have transferred
  task automatic run_frame(input string name, input int addr, input int flen,
                           input bit rnd_ready, input int inj_k, input int rst_at);
    int len, exp_len, idx, fv, fv_cyc, last_x, eop_c, done_c, t0;
    int gap_valid, max_occ, stab_err, addr_err, occ, budget;
    bit pv, pr, pe, ps, aborted;
    logic [7:0] pd;

    len = (flen > DEPTH) ? DEPTH : flen;
    exp_len = len;
`ifdef ETH_TX_PAD_EN
    if (len > 0 && len < MIN_LEN) exp_len = MIN_LEN;
`endif
    exp_q.delete();
    for (int i = 0; i < exp_len; i++)
      exp_q.push_back((i < len) ? mem[(addr + i) % DEPTH] : 8'h00);

    idx = 0; fv = -1; fv_cyc = -1; last_x = -1; eop_c = -1; done_c = -1;
    gap_valid = 0; max_occ = 0; stab_err = 0; addr_err = 0;
    pv = 1'b0; pr = 1'b0; pe = 1'b0; ps = 1'b0; pd = 8'h00; aborted = 1'b0;
    budget = exp_len * 8 + 200;

    @(negedge clk);
    addr_q.delete();
    rd_pulses  = 0;
    start      = 1'b1;
    start_addr = ADDR_W'(addr);
    frame_len  = LEN_W'(flen);
    tx_ready   = 1'b1;
    t0         = cyc;

    for (int k = 0; k < budget && done_c < 0; k++) begin
      @(negedge clk);
      if (k == inj_k) begin
        start      = 1'b1;
        start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        frame_len  = LEN_W'($urandom_range(1, 100));
      end else begin
        start = 1'b0;
      end
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (k == 0) chk({name, " busy_after_start"}, 32'(busy), 32'd1);

      occ = rd_pulses - ((idx < len) ? idx : len);
      if (occ > max_occ) max_occ = occ;

      if (pv && !pr)
        if (tx_valid !== 1'b1 || tx_data !== pd || tx_sop !== ps || tx_eop !== pe)
          stab_err++;

      if (tx_valid && fv < 0) begin
        fv     = cyc - t0;
        fv_cyc = cyc;
      end
      if (eop_c >= 0 && tx_valid) gap_valid++;

      if (tx_valid && tx_ready) begin
        if (idx < exp_len)
          chk($sformatf("%s byte%0d {sop,eop,data}", name, idx),
              {22'd0, tx_sop, tx_eop, tx_data},
              {22'd0, (idx == 0), (idx == exp_len - 1), exp_q[idx]});
        if (tx_eop) eop_c = cyc;
        last_x = cyc;
        idx++;
      end
      if (done) done_c = cyc;

      pv = tx_valid; pr = tx_ready; pd = tx_data; ps = tx_sop; pe = tx_eop;

      if (rst_at >= 0 && idx == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk({name, " outputs_in_reset"},
            32'({busy, done, buf_rd, buf_address, tx_valid, tx_sop, tx_eop, tx_data}), 32'd0);
        @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      chk({name, " done_seen"}, 32'(done_c >= 0), 32'd1);
      chk({name, " byte_count"}, 32'(idx), 32'(exp_len));
      chk({name, " buf_rd_pulses"}, 32'(rd_pulses), 32'(len));
      for (int i = 0; i < addr_q.size(); i++)
        if (addr_q[i] != (addr + i) % DEPTH) addr_err++;
      chk({name, " addr_sequence_errors"}, 32'(addr_err), 32'd0);
      chk({name, " fifo_occupancy_le2"}, 32'(max_occ <= 2), 32'd1);
      chk({name, " stall_stability_errors"}, 32'(stab_err), 32'd0);
      chk({name, " valid_during_gap"}, 32'(gap_valid), 32'd0);
      if (exp_len > 0) begin
        chk({name, " first_valid_latency"}, 32'(fv), 32'd3);
        chk({name, " eop_to_done"}, 32'(done_c - eop_c), 32'(IFG));
        if (!rnd_ready)
          chk({name, " back_to_back"}, 32'(last_x - fv_cyc), 32'(exp_len - 1));
      end else begin
        chk({name, " no_valid"}, 32'(fv), 32'hFFFF_FFFF);
        chk({name, " start_to_done"}, 32'(done_c - t0), 32'(IFG + 1));
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({name, " done_one_cycle"}, 32'(done), 32'd0);
      chk({name, " idle_after_done"}, 32'(busy), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a, l;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy_done", 32'({busy, done}), 32'd0);
    chk("reset buf_port", 32'({buf_rd, buf_address}), 32'd0);
    chk("reset stream", 32'({tx_valid, tx_sop, tx_eop, tx_data}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("basic", 0, 64, 1'b0, -1, -1);
    run_frame("wrap", 2040, 16, 1'b0, -1, -1);
    run_frame("bp20", $urandom_range(0, DEPTH - 1), 20, 1'b1, -1, -1);
    run_frame("bp200", $urandom_range(0, DEPTH - 1), 200, 1'b1, -1, -1);
    run_frame("len1", $urandom_range(0, DEPTH - 1), 1, 1'b0, -1, -1);
    run_frame("len1_bp", $urandom_range(0, DEPTH - 1), 1, 1'b1, -1, -1);
    run_frame("len0_start_at_done", $urandom_range(0, DEPTH - 1), 0, 1'b0, 12, -1);
    run_frame("len3000", $urandom_range(0, DEPTH - 1), 3000, 1'b0, -1, -1);
    run_frame("start_while_busy", $urandom_range(0, DEPTH - 1), 30, 1'b0, 8, -1);
    run_frame("reset_mid", $urandom_range(0, DEPTH - 1), 40, 1'b0, -1, 10);
    run_frame("after_reset", $urandom_range(0, DEPTH - 1), 64, 1'b0, -1, -1);
    run_frame("len42", 100, 42, 1'b0, -1, -1);
    run_frame("len42_bp", 2030, 42, 1'b1, -1, -1);
    run_frame("len59", $urandom_range(0, DEPTH - 1), 59, 1'b0, -1, -1);
    run_frame("len61_bp", $urandom_range(0, DEPTH - 1), 61, 1'b1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 130);
      run_frame($sformatf("rand%0d", r), a, l, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
